weight_fetcher: RTL
===================

WEIGHT_FETCHER -- requirements
Module: weight_fetcher

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16: weight-memory address width.
REQ-002 SHALL have parameter PACK, default 4: bytes packed per output word (power of two, >=1).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: output FIFO depth in words (power of two, >=2).
REQ-004 SHALL have port clock  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  job request, sampled only when idle.
REQ-007 SHALL have port base_addr  input  ADDR_WIDTH  first byte address of job.
REQ-008 SHALL have port length  input  ADDR_WIDTH+1  job length in bytes (0 legal).
REQ-009 SHALL have port busy  output  1  job in progress.
REQ-010 SHALL have port done  output  1  one-cycle job-complete pulse.
REQ-011 SHALL have port mem_read_addr  output  ADDR_WIDTH  memory read address.
REQ-012 SHALL have port mem_read_en  output  1  memory read request.
REQ-013 SHALL have port mem_read_data  input  8  memory read byte.
REQ-014 SHALL have port mem_read_valid  input  1  read byte valid; returns exactly 1 cycle after mem_read_en, with no backpressure.
REQ-015 SHALL have port out_data  output  8*PACK  packed weight word.
REQ-016 SHALL have port out_valid  output  1  out_data valid.
REQ-017 SHALL have port out_ready  input  1  downstream accepts word.
REQ-018 SHALL have port out_last  output  1  marks final word of job.

Function
REQ-019 SHALL implement FSM IDLE -> FETCH -> DRAIN -> DONE -> IDLE.
REQ-020 SHALL latch base_addr/length and leave IDLE on start=1 in IDLE; start SHALL be ignored in all other states.
REQ-021 SHALL go IDLE -> DONE directly when length=0: no reads, no output words, done one cycle after start.
REQ-022 SHALL issue byte i of the job at address (base_addr+i) mod 2^ADDR_WIDTH (wrap-around), i=0..length-1, in order, at most one per cycle.
REQ-023 SHALL issue a read only when credit>0, where credit = FIFO_DEPTH*PACK - (fifo_count*PACK + bytes_in_packer + reads_in_flight), so returned bytes are never dropped.
REQ-024 SHALL, with out_ready held 1, issue one read every cycle: first mem_read_en in the cycle after the start edge.
REQ-025 SHALL pack byte i into out_data bits [8*(i mod PACK)+7 : 8*(i mod PACK)] (little-endian).
REQ-026 SHALL push a word into the FIFO when the packer is full, or when the final byte arrives (zero-padding unused upper bytes); the final word SHALL carry out_last=1.
REQ-027 SHALL present FIFO head on out_data/out_valid/out_last; a word transfers when out_valid&out_ready; out_data/out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-028 SHALL first assert out_valid PACK+1 edges after the start edge when no stall occurs.
REQ-029 SHALL support a simultaneous FIFO push and pop in one cycle without count change.
REQ-030 SHALL move FETCH -> DRAIN after the last read is issued, and DRAIN -> DONE on transfer of the out_last word.
REQ-031 SHALL assert done=1 for exactly the one cycle in DONE; busy SHALL be 1 in FETCH and DRAIN, 0 in IDLE and DONE.
REQ-032 SHALL ignore mem_read_valid when no read is in flight.

Reset
REQ-033 SHALL, on reset=1 at any time including mid-job, return to IDLE, flush FIFO and packer, cancel in-flight reads, and drive busy, done, mem_read_en, out_valid, out_last = 0 and mem_read_addr, out_data = 0 on the next cycle.
REQ-034 SHALL discard any mem_read_valid arriving in the cycle after reset is released.

Structure
REQ-035 SHALL place the FSM state enum and PACK/FIFO_DEPTH defaults in package weight_fetch_pkg.
REQ-036 SHALL instantiate one sub-module fetch_fifo (synchronous FIFO, width 8*PACK+1, depth FIFO_DEPTH, with count output).

Verification
REQ-037 SHALL cover: base=0x0010, length=8, out_ready=1 -> reads 0x0010..0x0017 on 8 consecutive cycles; words 0x13121110, 0x17161514; out_last on 2nd; done once.
REQ-038 SHALL cover: base=0xFFFE, length=4 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001; single word 0x0100FFFE (memory pattern addr mod 256) with out_last.
REQ-039 SHALL cover: length=6, PACK=4 -> second word 0x00000504 relative to pattern, upper two bytes zero, out_last=1.
REQ-040 SHALL cover: length=32, out_ready=0 for 40 cycles -> exactly 16 reads issued, out_data stable, no lost bytes; after release all 8 words in order.
REQ-041 SHALL cover: length=0 -> no mem_read_en, no out_valid, done pulse one cycle after start; start during busy ignored.
REQ-042 SHALL cover: reset asserted mid-FETCH with one read in flight -> all outputs 0 next cycle; following job with base=0x0040 returns correct words.

Source files
------------

// File: rtl/weight_fetcher_pkg.sv
// weight_fetch_pkg: shared definitions for the weight fetcher.
//   fetch_state_e      - job FSM states
//   PACK_DEFAULT       - bytes packed per output word
//   FIFO_DEPTH_DEFAULT - output FIFO depth in words
package weight_fetch_pkg;

  localparam int PACK_DEFAULT       = 4;
  localparam int FIFO_DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/weight_fetcher_if.sv
// weight_fetcher_if: memory-read and packed-output streams of the weight fetcher.
//   mem_read_addr/en   - byte read request (fetcher -> memory)
//   mem_read_data/valid- read return, one cycle after the request
//   out_data/valid/last- packed weight word stream (fetcher -> consumer)
//   out_ready          - consumer accepts the current word
//   modport master: the fetcher side; modport slave: memory + consumer side
interface weight_fetcher_if
  import weight_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int PACK       = PACK_DEFAULT
) ();

  logic [ADDR_WIDTH-1:0] mem_read_addr;
  logic                  mem_read_en;
  logic [7:0]            mem_read_data;
  logic                  mem_read_valid;
  logic [8*PACK-1:0]     out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    output mem_read_addr, mem_read_en,
    input  mem_read_data, mem_read_valid,
    output out_data, out_valid, out_last,
    input  out_ready
  );

  modport slave (
    input  mem_read_addr, mem_read_en,
    output mem_read_data, mem_read_valid,
    input  out_data, out_valid, out_last,
    output out_ready
  );

endinterface

// File: rtl/weight_fetcher_fifo.sv
// fetch_fifo: small show-ahead synchronous FIFO.
//   clock, reset        - clock, synchronous active-high reset (flushes contents)
//   push, push_data     - write a word (ignored when full)
//   pop                 - drop the head word (ignored when empty)
//   head_data           - current head word, valid whenever !empty
//   count, full, empty  - occupancy
// The head is read combinationally so a word is visible the cycle after it
// is pushed; the depth is tiny, so this maps to distributed RAM.
module fetch_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push_ok, pop_ok;

  assign full      = (count_reg == (AW+1)'(DEPTH));
  assign empty     = (count_reg == '0);
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;
  assign head_data = mem_reg[rd_ptr_reg];
  assign count     = count_reg;

  always_ff @(posedge clock) begin
    if (push_ok) mem_reg[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      // Simultaneous push and pop leaves the count unchanged.
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/weight_fetcher.sv
// weight_fetcher: reads a run of bytes from weight memory, packs PACK bytes
// little-endian into words and streams them out through a small FIFO.
//   clock, reset        - clock, synchronous active-high reset
//   start               - job request, taken only in IDLE
//   base_addr, length   - first byte address and byte count of the job
//   busy                - high while fetching or draining
//   done                - one-cycle completion pulse
//   bus (master)        - memory read port and packed output stream
module weight_fetcher
  import weight_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int PACK       = PACK_DEFAULT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  weight_fetcher_if.master      bus
);

  localparam int LW  = ADDR_WIDTH + 1;
  localparam int WW  = 8 * PACK;
  localparam int PW  = $clog2(PACK) + 1;
  localparam int CAP = FIFO_DEPTH * PACK;
  localparam int CW  = $clog2(CAP) + 2;
  localparam int NW  = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e          state_reg, state_next;
  logic [ADDR_WIDTH-1:0] rd_addr_reg;
  logic [LW-1:0]         length_reg, issued_reg, recv_cnt_reg;
  logic                  inflight_reg;
  logic [PW-1:0]         pack_cnt_reg;
  logic [WW-1:0]         pack_data_reg;

  logic [CW-1:0] used;
  logic          issue, last_issue, accept, final_byte, push, pop;
  logic [WW-1:0] pack_word;
  logic [WW:0]   head_data;
  logic [NW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;

  // Every byte between issue and pop is accounted for here, so a read is only
  // issued when its returning byte is guaranteed a slot.
  assign used = CW'(fifo_count) * CW'(PACK) + CW'(pack_cnt_reg) + CW'(inflight_reg);

  assign issue      = (state_reg == ST_FETCH) && (used < CW'(CAP)) && !fifo_full;
  assign last_issue = issue && (issued_reg == length_reg - LW'(1));
  // A return with no read outstanding (e.g. just after reset) is stale.
  assign accept     = bus.mem_read_valid && inflight_reg;
  assign final_byte = (recv_cnt_reg == length_reg - LW'(1));

  // Incoming byte lands in its lane; packer lanes are cleared after each push,
  // which zero-pads a short final word.
  for (genvar gi = 0; gi < PACK; gi++) begin : g_lane
    assign pack_word[8*gi +: 8] = (accept && pack_cnt_reg == PW'(gi)) ?
                                  bus.mem_read_data : pack_data_reg[8*gi +: 8];
  end

  assign push = accept && ((pack_cnt_reg == PW'(PACK - 1)) || final_byte);
  assign pop  = !fifo_empty && bus.out_ready;

  fetch_fifo #(
    .WIDTH (WW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data ({final_byte, pack_word}),
    .pop       (pop),
    .head_data (head_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.mem_read_en   = issue;
  assign bus.mem_read_addr = rd_addr_reg;
  assign bus.out_valid     = !fifo_empty;
  assign bus.out_data      = fifo_empty ? '0 : head_data[WW-1:0];
  assign bus.out_last      = !fifo_empty && head_data[WW];
  assign busy              = (state_reg == ST_FETCH) || (state_reg == ST_DRAIN);
  assign done              = (state_reg == ST_DONE);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = (length == '0) ? ST_DONE : ST_FETCH;
      ST_FETCH: if (last_issue) state_next = ST_DRAIN;
      ST_DRAIN: if (pop && head_data[WW]) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      rd_addr_reg   <= '0;
      length_reg    <= '0;
      issued_reg    <= '0;
      recv_cnt_reg  <= '0;
      inflight_reg  <= 1'b0;
      pack_cnt_reg  <= '0;
      pack_data_reg <= '0;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= issue;
      if (state_reg == ST_IDLE && start) begin
        rd_addr_reg   <= base_addr;
        length_reg    <= length;
        issued_reg    <= '0;
        recv_cnt_reg  <= '0;
        pack_cnt_reg  <= '0;
        pack_data_reg <= '0;
      end else begin
        if (issue) begin
          rd_addr_reg <= rd_addr_reg + ADDR_WIDTH'(1);
          issued_reg  <= issued_reg + LW'(1);
        end
        if (accept) begin
          recv_cnt_reg <= recv_cnt_reg + LW'(1);
          if (push) begin
            pack_cnt_reg  <= '0;
            pack_data_reg <= '0;
          end else begin
            pack_cnt_reg  <= pack_cnt_reg + PW'(1);
            pack_data_reg <= pack_word;
          end
        end
      end
    end
  end

endmodule
